// File: rtl/uart_rx_fifo.sv
// Receive FIFO for a 16550A-style UART: stores bytes with parity/framing/break
// flags, first-word fall-through reads, and LSR/IIR status generation.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_en,
  input  logic                       clr,
  input  logic [1:0]                 trig_lvl,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pe_in,
  input  logic                       fe_in,
  input  logic                       bi_in,
  input  logic                       pop,
  input  logic                       ovr_clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       pe_out,
  output logic                       fe_out,
  output logic                       bi_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dr,
  output logic                       trigger,
  output logic                       overrun,
  output logic                       fifo_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 3;

  // Entry layout: {bi, fe, pe, data}
  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          overrun_q, overrun_d;
  logic          fifo_en_q;

  logic [EW-1:0] head;
  logic [CW-1:0] cap;
  logic [CW-1:0] thresh;
  logic          is_empty, is_full;
  logic          flush, do_push, do_pop, ovr_set;
  logic          in_err, head_err;

  function automatic logic [CW-1:0] trig_thresh(input logic en, input logic [1:0] lvl);
    logic [CW-1:0] t;
    if (!en) begin
      t = CW'(1);
    end else begin
      case (lvl)
        2'b00:   t = CW'(1);
        2'b01:   t = CW'(4);
        2'b10:   t = CW'(8);
        default: t = CW'(14);
      endcase
    end
    return t;
  endfunction

  always_comb begin
    head     = mem_q[rd_ptr_q];
    cap      = fifo_en_q ? CW'(DEPTH) : CW'(1);
    thresh   = trig_thresh(fifo_en_q, trig_lvl);
    is_empty = (count_q == '0);
    is_full  = (count_q == cap);
    // A mode change empties the FIFO just like an explicit receiver reset.
    flush    = clr | (fifo_en ^ fifo_en_q);
    do_pop   = pop & ~is_empty & ~flush;
    do_push  = push & (~is_full | do_pop) & ~flush;
    ovr_set  = push & is_full & ~do_pop & ~flush;
    in_err   = pe_in | fe_in | bi_in;
    head_err = |head[EW-1:WIDTH];
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case ({do_push & in_err, do_pop & head_err})
        2'b10:   err_cnt_d = err_cnt_q + CW'(1);
        2'b01:   err_cnt_d = err_cnt_q - CW'(1);
        default: err_cnt_d = err_cnt_q;
      endcase
    end
    // A new overrun wins over a simultaneous LSR read.
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      overrun_q <= 1'b0;
      fifo_en_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      overrun_q <= overrun_d;
      fifo_en_q <= fifo_en;
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {bi_in, fe_in, pe_in, din};
    end
  end

  always_comb begin
    dout     = is_empty ? '0 : head[WIDTH-1:0];
    pe_out   = ~is_empty & head[WIDTH];
    fe_out   = ~is_empty & head[WIDTH+1];
    bi_out   = ~is_empty & head[WIDTH+2];
    empty    = is_empty;
    full     = is_full;
    count    = count_q;
    dr       = ~is_empty;
    trigger  = ~is_empty & (count_q >= thresh);
    overrun  = overrun_q;
    fifo_err = (err_cnt_q != '0);
  end

endmodule
